fdivsqrt_otfc4_seq: RTL and testbench
=====================================

Name: fdivsqrt_otfc4_seq

Overview:
- Sequential radix-4 on-the-fly converter (OTFC) for the div/sqrt datapath.
- Consumes one signed radix-4 quotient/root digit per cycle in one-hot form. Maintains the running result U, its decrement UM (U minus one ULP of the last digit) and the thermometer position mask C.
- U, UM and C feed the radix-4 F addend generator and the post-processing stage.
- Owns the iteration count and a start/done handshake for the iteration loop.

Parameters:
- DIVb, default config_pkg::DIVb: fractional bits of U/UM/C; registers are Q4.DIVb, i.e. DIVb+4 bits.
- ITER, default (DIVb+2)/2: number of digit iterations per operation.

Ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous, active-low reset
- start  in  1  one-cycle request; honoured only when idle
- kill  in  1  abort the current operation; returns the block to idle
- stall  in  1  hold all state for this cycle; counter does not advance
- initU  in  DIVb+4  initial U, sampled on accepted start
- initUM  in  DIVb+4  initial UM, equal to initU minus 4*K0, sampled on start
- initC  in  DIVb+4  initial thermometer mask, sampled on start
- udigit  in  4  digit one-hot {+2,+1,-1,-2}; all zero means digit 0
- U  out  DIVb+4  running result
- UM  out  DIVb+4  running result minus ULP
- C  out  DIVb+4  current thermometer mask
- busy  out  1  iteration in progress
- done  out  1  one-cycle pulse after the last iteration
- digit_err  out  1  sticky flag: more than one udigit bit was hot while iterating

Behaviour:
- Reset (reset_n=0, asynchronous):
  - U=0, UM=0, C=0, busy=0, done=0, digit_err=0.
  - Counter cleared; FSM goes to IDLE.
- FSM states IDLE, ITERATE, DONE.
- IDLE:
  - start=1 and kill=0: load U/UM/C from the init inputs, counter=ITER, clear digit_err, go to ITERATE. busy rises the next cycle.
  - start with kill in the same cycle: kill wins, stay in IDLE.
- Per-cycle mask: K = C & ~(C<<1), a one-hot bit at the lowest set bit of C (the current digit weight).
- ITERATE: each cycle with stall=0 and kill=0, apply the digit update below, then C <= {2'b11, C[DIVb+3:2]} and counter decrements.
  - d=+2: U<=U|(K<<1), UM<=U|K
  - d=+1: U<=U|K, UM<=U
  - d=0: U<=U, UM<=UM|(K<<1)|K
  - d=-1: U<=UM|(K<<1)|K, UM<=UM|(K<<1)
  - d=-2: U<=UM|(K<<1), UM<=UM|K
- OR is exact, not an addition: bits below 4K in U and UM are always zero.
- Illegal digit (more than one udigit bit hot): priority order +2 > +1 > -1 > -2 selects the applied digit. digit_err is set and stays set until the next accepted start.
- Counter reaching 0 after an update: go to DONE. done=1 for exactly one cycle and busy drops in that same cycle. Then return to IDLE.
- U, UM and C hold their final values in IDLE until the next start.
- stall=1: all registers hold, including counter and FSM state. kill overrides stall.
- kill in ITERATE or DONE: next state IDLE, busy=0, no done pulse. U/UM/C hold their current values.
- start while busy or in DONE: ignored.
- C saturates at all-ones. K on all-ones C is bit 0; extra iterations beyond the mask width are a configuration error (ITER too large), not checked in RTL.
- Latency: start accepted at cycle 0, done asserted at cycle ITER+1 when there are no stalls. Each stall cycle adds one.

Decomposition:
- config_pkg: DIVb, plus a shared localparam for the udigit bit order {P2,P1,N1,N2}, also used by the F generator and digit selection.
- fsm_state_t enum (IDLE/ITERATE/DONE) stays local to this module.
- Sub-module fdivsqrt_otfc4_step: purely combinational next-U/UM from (U, UM, C, udigit). Reused by a future unrolled multi-digit-per-cycle variant.

Test Plan (DIVb=8, ITER=4, 12-bit values, initU=0x000, initUM=0xF00, initC=0xFC0):
- Digits +2,+1,-1,0 one per cycle, no stall -> U/UM after each step 0x080/0x040, 0x090/0x080, 0x08C/0x088, 0x08C/0x08B. done at cycle 5 and C=0xFFF.
- Same digits with stall=1 for 2 cycles after the second digit -> identical final U=0x08C, UM=0x08B; done at cycle 7; counter frozen during stall.
- Digits -2,-2,-2,-2 -> final U=0xF56 (-0.6640625), UM=0xF55; busy=0 the cycle after done.
- kill asserted in the second ITERATE cycle -> next cycle busy=0, no done pulse; a new start accepted the following cycle reloads the init values.
- udigit=4'b1100 in the first iteration -> treated as +2 (U=0x080), digit_err=1 and sticky through done; cleared by the next start.
- start pulsed while busy, and start+kill while idle -> both ignored; reset_n pulsed mid-operation -> all outputs 0 immediately.

Source files
------------

// File: rtl/config_pkg.sv
// Shared div/sqrt configuration: datapath width and the radix-4 digit encoding.
package config_pkg;

  // Fractional bits of the quotient/root datapath.
  localparam int DIVb = 24;

  // Bit positions within the one-hot udigit vector {P2,P1,N1,N2}.
  localparam int UD_P2 = 3;
  localparam int UD_P1 = 2;
  localparam int UD_N1 = 1;
  localparam int UD_N2 = 0;

  // True when more than one digit bit is hot.
  function automatic logic ud_multi(input logic [3:0] d);
    return (d & (d - 4'd1)) != 4'd0;
  endfunction

endpackage

// File: rtl/fdivsqrt_otfc4_step.sv
// One radix-4 OTFC step: next U/UM/C from the current state and one digit.
module fdivsqrt_otfc4_step #(
  parameter int W = 28
) (
  input  logic [W-1:0] u,
  input  logic [W-1:0] um,
  input  logic [W-1:0] c,
  input  logic [3:0]   udigit,
  output logic [W-1:0] nu,
  output logic [W-1:0] num,
  output logic [W-1:0] nc
);
  import config_pkg::*;

  logic [W-1:0] k;

  // K marks the lowest set bit of C; C shifts in ones two bits at a time.
  assign k  = c & ~(c << 1);
  assign nc = {2'b11, c[W-1:2]};

  // Digit selection with priority +2 > +1 > -1 > -2; all OR updates are exact.
  always_comb begin
    nu  = u;
    num = um | (k << 1) | k;
    if (udigit[UD_P2]) begin
      nu  = u | (k << 1);
      num = u | k;
    end else if (udigit[UD_P1]) begin
      nu  = u | k;
      num = u;
    end else if (udigit[UD_N1]) begin
      nu  = um | (k << 1) | k;
      num = um | (k << 1);
    end else if (udigit[UD_N2]) begin
      nu  = um | (k << 1);
      num = um | k;
    end
  end

endmodule

// File: rtl/fdivsqrt_otfc4_seq.sv
// Sequential radix-4 on-the-fly converter with iteration counter and start/done handshake.
module fdivsqrt_otfc4_seq #(
  parameter int DIVb = config_pkg::DIVb,
  parameter int ITER = (DIVb + 2) / 2
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            start,
  input  logic            kill,
  input  logic            stall,
  input  logic [DIVb+3:0] initU,
  input  logic [DIVb+3:0] initUM,
  input  logic [DIVb+3:0] initC,
  input  logic [3:0]      udigit,
  output logic [DIVb+3:0] U,
  output logic [DIVb+3:0] UM,
  output logic [DIVb+3:0] C,
  output logic            busy,
  output logic            done,
  output logic            digit_err
);
  import config_pkg::*;

  localparam int W  = DIVb + 4;
  localparam int CW = $clog2(ITER + 1);

  typedef enum logic [1:0] {IDLE, ITERATE, DONE} fsm_state_t;

  fsm_state_t    state, nstate;
  logic [CW-1:0] cnt;
  logic          load, upd;
  logic [W-1:0]  nu, num, nc;

  fdivsqrt_otfc4_step #(.W(W)) u_step (
    .u      (U),
    .um     (UM),
    .c      (C),
    .udigit (udigit),
    .nu     (nu),
    .num    (num),
    .nc     (nc)
  );

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= nstate;
  end

  // Next state and handshake outputs; kill beats stall, stall freezes everything else.
  always_comb begin
    nstate = state;
    load   = 1'b0;
    upd    = 1'b0;
    busy   = 1'b0;
    done   = 1'b0;
    case (state)
      IDLE: begin
        if (start && !kill && !stall) begin
          nstate = ITERATE;
          load   = 1'b1;
        end
      end
      ITERATE: begin
        busy = 1'b1;
        if (kill) begin
          nstate = IDLE;
        end else if (!stall) begin
          upd = 1'b1;
          if (cnt == CW'(1)) nstate = DONE;
        end
      end
      DONE: begin
        done = 1'b1;
        if (kill || !stall) nstate = IDLE;
      end
      default: nstate = IDLE;
    endcase
  end

  // Datapath registers: load on accepted start, step on each unstalled iteration.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      U         <= '0;
      UM        <= '0;
      C         <= '0;
      cnt       <= '0;
      digit_err <= 1'b0;
    end else if (load) begin
      U         <= initU;
      UM        <= initUM;
      C         <= initC;
      cnt       <= CW'(ITER);
      digit_err <= 1'b0;
    end else if (upd) begin
      U   <= nu;
      UM  <= num;
      C   <= nc;
      cnt <= cnt - CW'(1);
      if (ud_multi(udigit)) digit_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fdivsqrt_otfc4_seq.sv
// Self-checking bench: directed test-plan cases plus randomized ops against an arithmetic model.
module tb_fdivsqrt_otfc4_seq;
  localparam int DIVb = 8;
  localparam int ITER = 4;
  localparam int W    = DIVb + 4;

  localparam logic [3:0] D_P2 = 4'b1000;
  localparam logic [3:0] D_P1 = 4'b0100;
  localparam logic [3:0] D_Z  = 4'b0000;
  localparam logic [3:0] D_N1 = 4'b0010;
  localparam logic [3:0] D_N2 = 4'b0001;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         start = 1'b0, kill = 1'b0, stall = 1'b0;
  logic [W-1:0] initU = '0, initUM = '0, initC = '0;
  logic [3:0]   udigit = '0;
  logic [W-1:0] U, UM, C;
  logic         busy, done, digit_err;

  int pass_cnt = 0;
  int total_cnt = 0;

  // run_op stimulus and observations
  logic [W-1:0] iu, ium, ic;
  logic [3:0]   dig [ITER];
  logic [63:0]  stl;
  int           glitch_cyc;
  logic [W-1:0] obs_u [ITER];
  logic [W-1:0] obs_um [ITER];
  logic [W-1:0] obs_c;
  int           done_cyc;
  logic         err_done, err_c1, busy_c1, busy_done;

  // model results
  logic [W-1:0] exp_u [ITER];
  logic [W-1:0] exp_um [ITER];
  logic [W-1:0] exp_c;
  int           exp_done;

  fdivsqrt_otfc4_seq #(.DIVb(DIVb), .ITER(ITER)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .kill(kill), .stall(stall),
    .initU(initU), .initUM(initUM), .initC(initC), .udigit(udigit),
    .U(U), .UM(UM), .C(C), .busy(busy), .done(done), .digit_err(digit_err)
  );

  always #5 clk = ~clk;

  function automatic int dval(input logic [3:0] d);
    if (d[3]) return 2;
    if (d[2]) return 1;
    if (d[1]) return -1;
    if (d[0]) return -2;
    return 0;
  endfunction

  // Arithmetic reference: U += d*w with w the lowest set bit of C, UM = U - w.
  task automatic model();
    int u, c, w, cyc, k;
    u = int'(iu);
    c = int'(ic);
    for (int i = 0; i < ITER; i++) begin
      w = c & (-c);
      u = (u + dval(dig[i]) * w) & 'hFFF;
      exp_u[i]  = W'(u);
      exp_um[i] = W'((u - w) & 'hFFF);
      c = ((c >> 2) | 'hC00) & 'hFFF;
    end
    exp_c = W'(c);
    cyc = 1;
    k = 0;
    while (k < ITER) begin
      if (!stl[cyc]) k++;
      cyc++;
    end
    exp_done = cyc;
  endtask

  // Start one op, feed digits (holding a digit through stalls), record results; bounded.
  task automatic run_op();
    int cyc, k, pidx;
    logic pend;
    done_cyc = -1;
    err_done = 1'b0;
    busy_done = 1'b1;
    @(negedge clk);
    initU = iu; initUM = ium; initC = ic;
    start = 1'b1; kill = 1'b0; stall = 1'b0; udigit = '0;
    @(negedge clk);
    start = 1'b0;
    cyc = 1; k = 0; pend = 1'b0; pidx = 0;
    busy_c1 = busy;
    err_c1 = digit_err;
    while (cyc < 40) begin
      if (pend) begin
        obs_u[pidx] = U;
        obs_um[pidx] = UM;
        pend = 1'b0;
      end
      if (done) begin
        done_cyc = cyc;
        err_done = digit_err;
        busy_done = busy;
        obs_c = C;
        break;
      end
      start = (cyc == glitch_cyc);
      if (cyc == glitch_cyc) begin
        initU = 12'h555; initUM = 12'h111; initC = 12'h000;
      end
      stall = stl[cyc];
      udigit = (k < ITER) ? dig[k] : 4'b0000;
      if (!stall && k < ITER) begin
        pend = 1'b1;
        pidx = k;
        k++;
      end
      @(negedge clk);
      cyc++;
    end
    start = 1'b0; stall = 1'b0; udigit = '0;
  endtask

  task automatic set_plan_init();
    iu = 12'h000; ium = 12'hF00; ic = 12'hFC0;
    stl = '0;
    glitch_cyc = -1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    #3;
    total_cnt++;
    if ({U, UM, C, busy, done, digit_err} !== '0)
      $display("FAIL reset_state got U=%h UM=%h C=%h busy=%b done=%b err=%b want all 0",
               U, UM, C, busy, done, digit_err);
    else pass_cnt++;
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    logic [W-1:0] eu [ITER];
    logic [W-1:0] eum [ITER];
    eu  = '{12'h080, 12'h090, 12'h08C, 12'h08C};
    eum = '{12'h040, 12'h080, 12'h088, 12'h08B};
    set_plan_init();
    dig = '{D_P2, D_P1, D_N1, D_Z};
    run_op();
    total_cnt++;
    if (busy_c1 !== 1'b1) $display("FAIL basic_busy got %b want 1", busy_c1);
    else pass_cnt++;
    for (int i = 0; i < ITER; i++) begin
      total_cnt++;
      if (obs_u[i] !== eu[i] || obs_um[i] !== eum[i])
        $display("FAIL basic_step%0d got U=%h UM=%h want U=%h UM=%h", i, obs_u[i], obs_um[i], eu[i], eum[i]);
      else pass_cnt++;
    end
    total_cnt++;
    if (done_cyc !== 5 || obs_c !== 12'hFFF || busy_done !== 1'b0)
      $display("FAIL basic_done got cyc=%0d C=%h busy=%b want cyc=5 C=fff busy=0", done_cyc, obs_c, busy_done);
    else pass_cnt++;
    @(negedge clk);
    total_cnt++;
    if (done !== 1'b0 || busy !== 1'b0 || U !== 12'h08C)
      $display("FAIL basic_after got done=%b busy=%b U=%h want 0 0 08c", done, busy, U);
    else pass_cnt++;
  endtask

  task automatic test_stall();
    set_plan_init();
    dig = '{D_P2, D_P1, D_N1, D_Z};
    stl[3] = 1'b1;
    stl[4] = 1'b1;
    run_op();
    total_cnt++;
    if (obs_u[3] !== 12'h08C || obs_um[3] !== 12'h08B || done_cyc !== 7)
      $display("FAIL stall_final got U=%h UM=%h cyc=%0d want 08c 08b 7", obs_u[3], obs_um[3], done_cyc);
    else pass_cnt++;
    @(negedge clk);
  endtask

  task automatic test_neg2();
    set_plan_init();
    dig = '{D_N2, D_N2, D_N2, D_N2};
    run_op();
    total_cnt++;
    if (obs_u[3] !== 12'hF56 || obs_um[3] !== 12'hF55 || done_cyc !== 5)
      $display("FAIL neg2_final got U=%h UM=%h cyc=%0d want f56 f55 5", obs_u[3], obs_um[3], done_cyc);
    else pass_cnt++;
    @(negedge clk);
    total_cnt++;
    if (busy !== 1'b0 || done !== 1'b0)
      $display("FAIL neg2_after got busy=%b done=%b want 0 0", busy, done);
    else pass_cnt++;
  endtask

  task automatic test_kill();
    int n;
    logic saw_done;
    saw_done = 1'b0;
    @(negedge clk);
    initU = 12'h000; initUM = 12'hF00; initC = 12'hFC0; start = 1'b1;
    @(negedge clk);
    start = 1'b0; udigit = D_P2;
    @(negedge clk);
    udigit = D_P1; kill = 1'b1;
    saw_done = saw_done | done;
    @(negedge clk);
    kill = 1'b0; udigit = '0;
    saw_done = saw_done | done;
    total_cnt++;
    if (busy !== 1'b0 || saw_done !== 1'b0 || U !== 12'h080 || UM !== 12'h040)
      $display("FAIL kill_idle got busy=%b done_seen=%b U=%h UM=%h want 0 0 080 040", busy, saw_done, U, UM);
    else pass_cnt++;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    total_cnt++;
    if (busy !== 1'b1 || U !== 12'h000 || UM !== 12'hF00 || C !== 12'hFC0)
      $display("FAIL kill_restart got busy=%b U=%h UM=%h C=%h want 1 000 f00 fc0", busy, U, UM, C);
    else pass_cnt++;
    n = 0;
    while (!done && n < 20) begin
      @(negedge clk);
      n++;
    end
    total_cnt++;
    if (n !== 4) $display("FAIL kill_restart_done got %0d cycles want 4", n);
    else pass_cnt++;
    @(negedge clk);
  endtask

  task automatic test_illegal();
    set_plan_init();
    dig = '{4'b1100, D_P1, D_N1, D_Z};
    run_op();
    total_cnt++;
    if (obs_u[0] !== 12'h080 || err_done !== 1'b1)
      $display("FAIL illegal_digit got U=%h err_at_done=%b want 080 1", obs_u[0], err_done);
    else pass_cnt++;
    @(negedge clk);
    total_cnt++;
    if (digit_err !== 1'b1) $display("FAIL illegal_sticky got %b want 1", digit_err);
    else pass_cnt++;
    dig = '{D_P2, D_P1, D_N1, D_Z};
    run_op();
    total_cnt++;
    if (err_c1 !== 1'b0 || err_done !== 1'b0)
      $display("FAIL illegal_clear got c1=%b done=%b want 0 0", err_c1, err_done);
    else pass_cnt++;
    @(negedge clk);
  endtask

  task automatic test_ignored_start();
    set_plan_init();
    dig = '{D_P2, D_P1, D_N1, D_Z};
    glitch_cyc = 2;
    run_op();
    total_cnt++;
    if (obs_u[3] !== 12'h08C || obs_um[3] !== 12'h08B || done_cyc !== 5)
      $display("FAIL start_busy got U=%h UM=%h cyc=%0d want 08c 08b 5", obs_u[3], obs_um[3], done_cyc);
    else pass_cnt++;
    @(negedge clk);
    start = 1'b1; kill = 1'b1;
    @(negedge clk);
    start = 1'b0; kill = 1'b0;
    total_cnt++;
    if (busy !== 1'b0 || U !== 12'h08C)
      $display("FAIL start_kill_idle got busy=%b U=%h want 0 08c", busy, U);
    else pass_cnt++;
  endtask

  task automatic test_random();
    int p, bad;
    bad = 0;
    for (int t = 0; t < 24; t++) begin
      p = 6 + $urandom_range(0, 2);
      iu = W'($urandom) & ~W'((1 << (p + 2)) - 1);
      ium = iu - W'(4 << p);
      ic = ~W'((1 << p) - 1);
      stl = '0;
      for (int s = 1; s < 16; s++) stl[s] = ($urandom_range(0, 3) == 0);
      glitch_cyc = -1;
      for (int i = 0; i < ITER; i++) begin
        case ($urandom_range(0, 4))
          0: dig[i] = D_P2;
          1: dig[i] = D_P1;
          2: dig[i] = D_Z;
          3: dig[i] = D_N1;
          default: dig[i] = D_N2;
        endcase
      end
      model();
      run_op();
      for (int i = 0; i < ITER; i++) begin
        total_cnt++;
        if (obs_u[i] !== exp_u[i] || obs_um[i] !== exp_um[i]) begin
          $display("FAIL rand_op%0d_step%0d got U=%h UM=%h want U=%h UM=%h", t, i, obs_u[i], obs_um[i], exp_u[i], exp_um[i]);
          bad++;
        end else pass_cnt++;
      end
      total_cnt++;
      if (done_cyc !== exp_done || obs_c !== exp_c)
        $display("FAIL rand_op%0d_done got cyc=%0d C=%h want cyc=%0d C=%h", t, done_cyc, obs_c, exp_done, exp_c);
      else pass_cnt++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    initU = 12'h000; initUM = 12'hF00; initC = 12'hFC0; start = 1'b1;
    @(negedge clk);
    start = 1'b0; udigit = 4'b1100;
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    total_cnt++;
    if ({U, UM, C, busy, done, digit_err} !== '0)
      $display("FAIL reset_mid got U=%h UM=%h C=%h busy=%b done=%b err=%b want all 0",
               U, UM, C, busy, done, digit_err);
    else pass_cnt++;
    udigit = '0;
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    total_cnt++;
    if (busy !== 1'b0 || U !== '0) $display("FAIL reset_mid_idle got busy=%b U=%h want 0 000", busy, U);
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_neg2();
    test_kill();
    test_illegal();
    test_ignored_start();
    test_random();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
